// File: rtl/result_serializer_if.sv
// ---------------------------------------------------------------------------
// result_serializer_if
//   Serial output link of the result serializer. Valid/ready contract: a bit
//   moves on every rising clock edge where sout_valid and sout_ready are both
//   high. While sout_valid is high and sout_ready is low, the source holds
//   sout, frame_start and frame_end stable. sout_valid never drops inside a
//   frame. frame_start and frame_end are meaningful only while sout_valid is
//   high.
//
//   Signals
//     sout         serial data bit              (master -> slave)
//     sout_valid   sout holds a valid bit       (master -> slave)
//     frame_start  sout is bit 0 of a frame     (master -> slave)
//     frame_end    sout is last bit of a frame  (master -> slave)
//     sout_ready   sink accepts the bit         (slave  -> master)
// ---------------------------------------------------------------------------
interface result_serializer_if;
    logic sout;
    logic sout_valid;
    logic sout_ready;
    logic frame_start;
    logic frame_end;

    modport master (
        output sout,
        output sout_valid,
        output frame_start,
        output frame_end,
        input  sout_ready
    );

    modport slave (
        input  sout,
        input  sout_valid,
        input  frame_start,
        input  frame_end,
        output sout_ready
    );
endinterface

// File: rtl/result_serializer.sv
// ---------------------------------------------------------------------------
// result_serializer
//   Captures WIDTH parallel compressor result bits on a capture strobe and
//   streams them out one bit per accepted transfer on a valid/ready serial
//   link, marking the first and last bit of each frame. Captures that arrive
//   while a frame is still streaming are dropped and counted in a saturating
//   overrun counter. A capture that coincides with the final transfer of a
//   frame starts the next frame with no idle gap.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     capture      1-cycle strobe: latch din as a new frame
//     din          parallel result, bit i is dst<i>
//     ser          serial link (master side): sout, sout_valid, frame_start,
//                  frame_end out; sout_ready in
//     busy         frame in progress
//     overrun_cnt  number of dropped captures, saturates at all-ones
//     state_dbg    FSM state (0 = IDLE, 1 = SHIFT)
//
//   Every output is a register or a decode of registers only; nothing on the
//   input side reaches an output combinationally.
// ---------------------------------------------------------------------------
module result_serializer #(
    parameter int WIDTH     = 28,
    parameter bit LSB_FIRST = 1'b1,
    parameter int OVF_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic [WIDTH-1:0]     din,
    result_serializer_if.master  ser,
    output logic                 busy,
    output logic [OVF_W-1:0]     overrun_cnt,
    output logic                 state_dbg
);

    localparam int            CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    // Bit of the shift register that is currently on the wire.
    localparam int            OUT_IDX  = LSB_FIRST ? 0 : WIDTH - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [OVF_W-1:0]   ovf_q,   ovf_d;

    logic               xfer;
    logic               last_bit;
    logic [WIDTH-1:0]   shreg_shifted;

    // Move the next bit toward the output end; vacated positions fill with 0.
    assign shreg_shifted = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                     : {shreg_q[WIDTH-2:0], 1'b0};

    assign xfer     = (state_q == SHIFT) && ser.sout_ready;
    assign last_bit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (xfer) begin
                    if (last_bit) begin
                        if (capture) begin
                            // Back-to-back frame: reload on the final transfer.
                            shreg_d = din;
                            cnt_d   = '0;
                        end else begin
                            // Clear so IDLE drives a quiet 0 on sout.
                            shreg_d = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = shreg_shifted;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end

                // Any capture that is not consumed by a reload is lost.
                if (capture && !(xfer && last_bit) && (ovf_q != '1)) begin
                    ovf_d = ovf_q + OVF_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ser.sout        = (state_q == SHIFT) ? shreg_q[OUT_IDX] : 1'b0;
    assign ser.sout_valid  = (state_q == SHIFT);
    assign ser.frame_start = (state_q == SHIFT) && (cnt_q == '0);
    assign ser.frame_end   = (state_q == SHIFT) && last_bit;
    assign busy            = (state_q == SHIFT);
    assign overrun_cnt     = ovf_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_result_serializer.sv
module tb_result_serializer;

    localparam int W = 28;

    logic          clk;
    logic          rst;
    logic          capture;
    logic [W-1:0]  din;
    logic          busy;
    logic [7:0]    overrun_cnt;
    logic          state_dbg;

    logic          capture2;
    logic [W-1:0]  din2;
    logic          busy2;
    logic [7:0]    overrun_cnt2;
    logic          state_dbg2;

    result_serializer_if ser_if ();
    result_serializer_if ser_if2 ();

    result_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .OVF_W(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .din         (din),
        .ser         (ser_if),
        .busy        (busy),
        .overrun_cnt (overrun_cnt),
        .state_dbg   (state_dbg)
    );

    result_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .OVF_W(8)) u_dut_msb (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture2),
        .din         (din2),
        .ser         (ser_if2),
        .busy        (busy2),
        .overrun_cnt (overrun_cnt2),
        .state_dbg   (state_dbg2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Remaining bits of the frame on the wire, in transmit order.
    logic       exp_q[$];
    logic [7:0] m_ovf;

    function automatic void model_load(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
    endfunction

    // Sampled DUT outputs from the last step.
    logic s_valid, s_sout, s_fs, s_fe, s_busy;
    logic [7:0] s_ovf;

    // One clock cycle: sample and check at the falling edge, then drive
    // the inputs for the next rising edge and advance the model.
    task automatic step(input logic cap, input logic [W-1:0] d, input logic rdy);
        logic [12:0] got;
        logic [12:0] exp;
        logic        mv;
        logic        xf;
        @(negedge clk);
        s_valid = ser_if.sout_valid;
        s_sout  = ser_if.sout;
        s_fs    = ser_if.frame_start;
        s_fe    = ser_if.frame_end;
        s_busy  = busy;
        s_ovf   = overrun_cnt;
        mv  = (exp_q.size() != 0);
        exp = {mv, mv ? exp_q[0] : 1'b0, mv && (exp_q.size() == W),
               mv && (exp_q.size() == 1), mv, m_ovf};
        got = {s_valid, s_sout, s_fs, s_fe, s_busy, s_ovf};
        chk("cycle", 32'(got), 32'(exp));

        capture = cap;
        din     = d;
        ser_if.sout_ready = rdy;

        xf = mv && rdy;
        if (xf) void'(exp_q.pop_front());
        if (cap) begin
            if (!mv || (xf && exp_q.size() == 0)) model_load(d);
            else if (m_ovf != 8'hFF) m_ovf++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        capture = 1'b0;
        din = '0;
        ser_if.sout_ready = 1'b0;
        #1;
        chk("reset_out", 32'({ser_if.sout_valid, ser_if.sout, ser_if.frame_start,
                              ser_if.frame_end, busy, overrun_cnt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_ovf = '0;
    endtask

    // Capture d and collect one full frame. mode 0: ready always high;
    // mode 1: ready pattern 1,0,0 repeating from the first valid cycle.
    task automatic run_frame(input logic [W-1:0] d, input int mode,
                             output logic [W-1:0] word, output int ncyc);
        int  k;
        int  i;
        logic rdy;
        word = '0;
        ncyc = 0;
        k = 0;
        i = 0;
        step(1'b1, d, 1'b1);
        while (k < W && i < 400) begin
            rdy = (mode == 0) ? 1'b1 : ((i % 3) == 0);
            step(1'b0, '0, rdy);
            if (i == 0) chk("latency_fs", 32'({s_valid, s_fs}), 32'b11);
            if (s_valid) ncyc++;
            if (s_valid && rdy) begin
                word[k] = s_sout;
                k++;
            end
            i++;
        end
        if (k < W) chk("frame_timeout", 32'(k), 32'(W));
    endtask

    typedef struct {
        logic [W-1:0] din;
        int           mode;
        logic [W-1:0] exp_word;
        int           exp_cycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [W-1:0] word;
        int           ncyc;
        int           ones;
        int           allv;
        logic [W-1:0] rd;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        capture = 1'b0;
        din = '0;
        ser_if.sout_ready = 1'b0;
        capture2 = 1'b0;
        din2 = '0;
        ser_if2.sout_ready = 1'b1;
        m_ovf = '0;

        vecs[0] = '{28'h5A3C0F1, 0, 28'h5A3C0F1, 28};
        vecs[1] = '{28'h0000001, 1, 28'h0000001, 82};
        vecs[2] = '{28'hFFFFFFF, 0, 28'hFFFFFFF, 28};
        vecs[3] = '{28'h0000000, 1, 28'h0000000, 82};
        vecs[4] = '{28'hAAAAAAA, 1, 28'hAAAAAAA, 82};

        #12;
        chk("reset_initial", 32'({ser_if.sout_valid, ser_if.sout, ser_if.frame_start,
                                  ser_if.frame_end, busy, overrun_cnt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single frames.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            run_frame(vecs[v].din, vecs[v].mode, word, ncyc);
            chk("frame_word", 32'(word), 32'(vecs[v].exp_word));
            chk("frame_cycles", 32'(ncyc), 32'(vecs[v].exp_cycles));
            step(1'b0, '0, 1'b1);
            chk("busy_after", 32'(s_busy), 32'd0);
        end

        // Back-to-back frames on the final transfer.
        do_reset();
        step(1'b1, 28'hFFFFFFF, 1'b1);
        ones = 0;
        allv = 1;
        for (int i = 0; i < 2 * W; i++) begin
            step(i == W - 1, 28'h0000000, 1'b1);
            if (!s_valid) allv = 0;
            if (i < W && s_sout) ones++;
            if (i >= W && s_sout) ones += 100;
        end
        chk("b2b_contig", 32'(allv), 32'd1);
        chk("b2b_bits", 32'(ones), 32'(W));
        chk("b2b_ovf", 32'(s_ovf), 32'd0);

        // Overrun saturation while a frame is held by back-pressure.
        do_reset();
        step(1'b1, 28'h1234567, 1'b0);
        for (int i = 0; i < 300; i++) begin
            rd = W'($urandom);
            step(1'b1, rd, 1'b0);
        end
        word = '0;
        for (int i = 0; i < W; i++) begin
            step(1'b0, '0, 1'b1);
            word[i] = s_sout;
        end
        chk("ovr_word", 32'(word), 32'h1234567);
        chk("ovr_cnt", 32'(s_ovf), 32'd255);

        // Reset in the middle of a frame at bit 10.
        do_reset();
        step(1'b1, 28'h5A3C0F1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        @(posedge clk);
        #2;
        chk("mid_valid", 32'(ser_if.sout_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_reset_out", 32'({ser_if.sout_valid, ser_if.sout, ser_if.frame_start,
                                  ser_if.frame_end, busy, overrun_cnt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        capture = 1'b0;
        exp_q.delete();
        m_ovf = '0;
        run_frame(28'h0000003, 0, word, ncyc);
        chk("post_reset_word", 32'(word), 32'h0000003);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rd = W'($urandom);
            step($urandom_range(0, 7) == 0, rd, $urandom_range(0, 3) != 0);
        end

        // MSB-first instance.
        @(negedge clk);
        capture2 = 1'b1;
        din2 = 28'h8000000;
        @(negedge clk);
        capture2 = 1'b0;
        chk("msb_first", 32'({ser_if2.sout_valid, ser_if2.sout, ser_if2.frame_start}), 32'b111);
        ones = 0;
        allv = 1;
        for (int i = 0; i < W; i++) begin
            if (!ser_if2.sout_valid) allv = 0;
            if (ser_if2.sout) ones++;
            @(negedge clk);
        end
        chk("msb_ones", 32'(ones), 32'd1);
        chk("msb_valid", 32'(allv), 32'd1);
        chk("msb_busy_after", 32'(busy2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
